// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential binary-to-BCD converter (shift-and-add-3)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  conversion request, sampled only while idle
//   bin    WIDTH-bit unsigned value, captured when start is accepted
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when bcd has just been updated
//   bcd    4*DIGITS packed BCD result, digit 0 (units) in [3:0]
//   blank  DIGITS-bit leading-zero mask (only when BCD_BLANK_EN is defined)
//
// Optional feature macro: BCD_BLANK_EN

module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int SW = 4 * DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sh_q;
    logic [SW-1:0]   sh_adj;
    logic [SW-1:0]   sh_next;
    logic [CW-1:0]   cnt_q;
    logic            last;
    logic            load;
    logic            fin;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes and the per-iteration datapath
    always_comb begin
        load   = (state_q == IDLE) && start;
        fin    = (state_q == SHIFT) && last;
        sh_adj = sh_q;
        // Only the BCD field above the binary bits is corrected; a nibble
        // of 5 or more would overflow past 9 once doubled by the shift.
        for (int k = 0; k < DIGITS; k++) begin
            if (sh_q[WIDTH + 4*k +: 4] >= 4'd5) begin
                sh_adj[WIDTH + 4*k +: 4] = sh_q[WIDTH + 4*k +: 4] + 4'd3;
            end
        end
        sh_next = sh_adj << 1;
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic              all_zero;

    // Digit k is blank when it and every digit above it are zero; the
    // units digit is never blanked so zero still shows as "0".
    always_comb begin
        blank_d  = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero && (sh_next[WIDTH + 4*k +: 4] == 4'd0);
            blank_d[k] = all_zero;
        end
    end
`endif

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
            bcd   <= '0;
`ifdef BCD_BLANK_EN
            blank <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            done <= fin;
            if (load) begin
                sh_q  <= {{(4*DIGITS){1'b0}}, bin};
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                sh_q  <= sh_next;
                cnt_q <= cnt_q + CW'(1);
            end
            if (fin) begin
                bcd   <= sh_next[SW-1 -: 4*DIGITS];
`ifdef BCD_BLANK_EN
                blank <= blank_d;
`endif
            end
        end
    end

    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq

module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    int checks   = 0;
    int failures = 0;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [19:0] exp_bcd;
        logic [4:0]  exp_blank;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by plain division
    function automatic logic [19:0] model_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input int unsigned v);
        logic [4:0] r;
        int unsigned p;
        r = '0;
        p = 10;
        for (int k = 1; k < DIGITS; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check_blank(input string name, input logic [4:0] exp);
`ifdef BCD_BLANK_EN
        check(name, {27'b0, blank}, {27'b0, exp});
`else
        if (exp === 5'bx) $display("unused");
`endif
    endtask

    // Runs one conversion, checks busy length and latency, leaves bench in the cycle after done
    task automatic convert(input logic [15:0] v, input string name);
        int n;
        int busy_cnt;
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 16'($urandom);
        n = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            tick();
            n++;
        end
        check({name, "_latency"}, n, WIDTH);
        check({name, "_busy_cycles"}, busy_cnt, WIDTH);
        check({name, "_busy_in_done"}, {31'b0, busy}, 0);
        check({name, "_bcd"}, {12'b0, bcd}, {12'b0, model_bcd(32'(v))});
        check_blank({name, "_blank"}, model_blank(32'(v)));
        tick();
        check({name, "_done_width"}, {31'b0, done}, 0);
    endtask

    initial begin
        int dcount;
        int n;
        logic [15:0] r;

        vecs[0] = '{16'd0,     20'h00000, 5'b11110};
        vecs[1] = '{16'd65535, 20'h65535, 5'b00000};
        vecs[2] = '{16'd1234,  20'h01234, 5'b10000};
        vecs[3] = '{16'd9,     20'h00009, 5'b11110};
        vecs[4] = '{16'd10,    20'h00010, 5'b11100};
        vecs[5] = '{16'd10000, 20'h10000, 5'b00000};

        rst = 1'b1; start = 1'b0; bin = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_bcd",  {12'b0, bcd}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        check_blank("reset_blank", 5'b11110);

        // Table vectors: constants checked directly, plus the full convert checks
        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].value, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_table_bcd", i), {12'b0, bcd}, {12'b0, vecs[i].exp_bcd});
            check_blank($sformatf("vec%0d_table_blank", i), vecs[i].exp_blank);
        end

        // Random values against the reference model
        for (int i = 0; i < 20; i++) begin
            r = 16'($urandom);
            convert(r, $sformatf("rand%0d", i));
        end

        // Ignored start during conversion
        bin = 16'd1000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bin = 16'd42; start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 45; i++) begin
            if (done) dcount++;
            tick();
        end
        check("ignored_done_count", dcount, 1);
        check("ignored_bcd", {12'b0, bcd}, 32'h01000);
        check("ignored_idle", {31'b0, busy}, 0);

        // Back-to-back with start held
        bin = 16'd500; start = 1'b1;
        tick();
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        check("b2b_first_done_seen", {31'b0, done}, 1);
        check("b2b_first_bcd", {12'b0, bcd}, 32'h00500);
        bin = 16'd77;
        tick();
        n = 1;
        while (!done && n < 40) begin tick(); n++; end
        start = 1'b0;
        check("b2b_spacing", n, WIDTH + 1);
        check("b2b_second_bcd", {12'b0, bcd}, 32'h00077);
        for (int i = 0; i < 20; i++) tick();

        // Reset mid-conversion
        bin = 16'd4321; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_bcd", {12'b0, bcd}, 0);
        check_blank("midrst_blank", 5'b11110);
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) dcount++;
            tick();
        end
        check("midrst_no_done", dcount, 0);
        convert(16'd4321, "after_rst");
        check("after_rst_bcd_const", {12'b0, bcd}, 32'h04321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
